// File: rtl/set_access_controller_pkg.sv
// Shared types and helpers for the per-set access controller and its LRU neighbour.
// Holds the controller state encoding and one-hot helper functions.
// Functions are sized for up to MAX_WAYS ways; callers cast to their own width.
package set_access_controller_pkg;

   localparam int MAX_WAYS  = 32;
   localparam int MAX_IDX_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WB,
      FILL_REQ,
      FILL_WAIT,
      ALLOC,
      RESP
   } state_e;

   // Keeps only the lowest set bit; also used to sanitise a malformed LRU target.
   function automatic logic [MAX_WAYS-1:0] lowest_set_oh(input logic [MAX_WAYS-1:0] v);
      return v & (~v + MAX_WAYS'(1));
   endfunction

   // One-hot to binary index; an all-zero input yields index 0.
   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_WAYS-1:0] oh);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_WAYS; i++) begin
         if (oh[i]) begin
            idx = idx | MAX_IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/set_access_controller_if.sv
// Request, response, LRU, writeback and fill signals of one cache-set controller.
// The slave modport is the controller's view; master is the environment's view.
// Flow control is valid/ready on request, writeback and fill; responses are pulses.
interface set_access_controller_if #(
   parameter int NUM_WAYS  = 4,
   parameter int TAG_WIDTH = 20
);
   logic                 req_valid;
   logic                 req_ready;
   logic [TAG_WIDTH-1:0] req_tag;
   logic                 req_write;
   logic                 resp_valid;
   logic                 resp_hit;
   logic [NUM_WAYS-1:0]  resp_way;
   logic [NUM_WAYS-1:0]  hit_way;
   logic [NUM_WAYS-1:0]  allocate_way;
   logic [NUM_WAYS-1:0]  eviction_target;
   logic                 eviction_ready;
   logic                 wb_valid;
   logic                 wb_ready;
   logic [TAG_WIDTH-1:0] wb_tag;
   logic                 fill_valid;
   logic                 fill_ready;
   logic [TAG_WIDTH-1:0] fill_tag;
   logic                 fill_done;

   modport slave (
      input  req_valid, req_tag, req_write, eviction_target, eviction_ready,
             wb_ready, fill_ready, fill_done,
      output req_ready, resp_valid, resp_hit, resp_way, hit_way, allocate_way,
             wb_valid, wb_tag, fill_valid, fill_tag
   );

   modport master (
      output req_valid, req_tag, req_write, eviction_target, eviction_ready,
             wb_ready, fill_ready, fill_done,
      input  req_ready, resp_valid, resp_hit, resp_way, hit_way, allocate_way,
             wb_valid, wb_tag, fill_valid, fill_tag
   );

endinterface

// File: rtl/set_access_controller_tag_store.sv
// Per-way tag/valid/dirty state for one set, with combinational match and free-way search.
// Lookup outputs are combinational; writes land on the next clock edge.
// No backpressure: allocate and set-dirty ports are never used in the same cycle.
module set_access_controller_tag_store
   import set_access_controller_pkg::*;
#(
   parameter int NUM_WAYS  = 4,
   parameter int TAG_WIDTH = 20,
   parameter int IDX_W     = $clog2(NUM_WAYS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [TAG_WIDTH-1:0] lookup_tag_i,
   output logic [NUM_WAYS-1:0]  match_o,
   output logic [NUM_WAYS-1:0]  valid_o,
   output logic [NUM_WAYS-1:0]  dirty_o,
   output logic [NUM_WAYS-1:0]  invalid_oh_o,
   input  logic [IDX_W-1:0]     rd_idx_i,
   output logic [TAG_WIDTH-1:0] rd_tag_o,
   input  logic                 alloc_en_i,
   input  logic [IDX_W-1:0]     alloc_idx_i,
   input  logic [TAG_WIDTH-1:0] alloc_tag_i,
   input  logic                 alloc_dirty_i,
   input  logic                 set_dirty_en_i,
   input  logic [IDX_W-1:0]     set_dirty_idx_i
);

   logic [TAG_WIDTH-1:0] tag_q [NUM_WAYS];
   logic [NUM_WAYS-1:0]  valid_q;
   logic [NUM_WAYS-1:0]  dirty_q;

   // Allocation rewrites a whole way; a write hit only raises the dirty bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            tag_q[w] <= '0;
         end
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (alloc_en_i && (alloc_idx_i == IDX_W'(w))) begin
               tag_q[w]   <= alloc_tag_i;
               valid_q[w] <= 1'b1;
               dirty_q[w] <= alloc_dirty_i;
            end else if (set_dirty_en_i && (set_dirty_idx_i == IDX_W'(w))) begin
               dirty_q[w] <= 1'b1;
            end
         end
      end
   end

   // Match every valid way against the lookup tag in parallel.
   always_comb begin
      match_o = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         match_o[w] = valid_q[w] && (tag_q[w] == lookup_tag_i);
      end
   end

   assign valid_o      = valid_q;
   assign dirty_o      = dirty_q;
   assign invalid_oh_o = NUM_WAYS'(lowest_set_oh(MAX_WAYS'(~valid_q)));
   assign rd_tag_o     = tag_q[rd_idx_i];

endmodule

// File: rtl/set_access_controller.sv
// Per-set lookup controller: hit/miss resolution, victim choice, writeback and fill sequencing.
// Hit responds 2 cycles after accept; clean miss with immediate memory handshakes responds at 5.
// One request outstanding: req_ready only in IDLE; wb/fill requests hold until their ready.
module set_access_controller
   import set_access_controller_pkg::*;
#(
   parameter int NUM_WAYS  = 4,
   parameter int TAG_WIDTH = 20
) (
   input  logic                   clk,
   input  logic                   reset,
   set_access_controller_if.slave bus
);

   localparam int IDX_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

   state_e               state_q, state_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic                 write_q, write_d;
   logic [NUM_WAYS-1:0]  victim_q, victim_d;
   logic [NUM_WAYS-1:0]  way_q, way_d;
   logic                 hit_q, hit_d;

   logic [NUM_WAYS-1:0]  match_vec;
   logic [NUM_WAYS-1:0]  valid_vec;
   logic [NUM_WAYS-1:0]  dirty_vec;
   logic [NUM_WAYS-1:0]  invalid_oh;
   logic [TAG_WIDTH-1:0] victim_tag;
   logic [IDX_W-1:0]     victim_idx;
   logic [IDX_W-1:0]     match_idx;
   logic [NUM_WAYS-1:0]  lru_pick;
   logic [NUM_WAYS-1:0]  pick;
   logic                 alloc_en;
   logic                 set_dirty_en;

   // The LRU block shares this reset so its ages restart alongside the tag state.
   set_access_controller_tag_store #(
      .NUM_WAYS  (NUM_WAYS),
      .TAG_WIDTH (TAG_WIDTH),
      .IDX_W     (IDX_W)
   ) u_store (
      .clk             (clk),
      .reset           (reset),
      .lookup_tag_i    (tag_q),
      .match_o         (match_vec),
      .valid_o         (valid_vec),
      .dirty_o         (dirty_vec),
      .invalid_oh_o    (invalid_oh),
      .rd_idx_i        (victim_idx),
      .rd_tag_o        (victim_tag),
      .alloc_en_i      (alloc_en),
      .alloc_idx_i     (victim_idx),
      .alloc_tag_i     (tag_q),
      .alloc_dirty_i   (write_q),
      .set_dirty_en_i  (set_dirty_en),
      .set_dirty_idx_i (match_idx)
   );

   assign victim_idx = IDX_W'(onehot_to_idx(MAX_WAYS'(victim_q)));
   assign match_idx  = IDX_W'(onehot_to_idx(MAX_WAYS'(match_vec)));
   // A malformed multi-hot target degrades to its lowest set bit.
   assign lru_pick   = NUM_WAYS'(lowest_set_oh(MAX_WAYS'(bus.eviction_target)));

   // State and per-request context registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         tag_q    <= '0;
         write_q  <= 1'b0;
         victim_q <= '0;
         way_q    <= '0;
         hit_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tag_q    <= tag_d;
         write_q  <= write_d;
         victim_q <= victim_d;
         way_q    <= way_d;
         hit_q    <= hit_d;
      end
   end

   // Next-state and output decode; every output is zero outside the state that owns it.
   always_comb begin
      state_d          = state_q;
      tag_d            = tag_q;
      write_d          = write_q;
      victim_d         = victim_q;
      way_d            = way_q;
      hit_d            = hit_q;
      pick             = '0;
      alloc_en         = 1'b0;
      set_dirty_en     = 1'b0;
      bus.req_ready    = 1'b0;
      bus.resp_valid   = 1'b0;
      bus.resp_hit     = 1'b0;
      bus.resp_way     = '0;
      bus.hit_way      = '0;
      bus.allocate_way = '0;
      bus.wb_valid     = 1'b0;
      bus.wb_tag       = '0;
      bus.fill_valid   = 1'b0;
      bus.fill_tag     = '0;

      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               tag_d   = bus.req_tag;
               write_d = bus.req_write;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (|match_vec) begin
               bus.hit_way  = match_vec;
               set_dirty_en = write_q;
               hit_d        = 1'b1;
               way_d        = match_vec;
               state_d      = RESP;
            end else begin
               // Free ways are filled first; the LRU target is only consulted when the
               // set is full, and never in a cycle carrying an LRU update pulse.
               if (|invalid_oh) begin
                  pick = invalid_oh;
               end else if (bus.eviction_ready) begin
                  pick = lru_pick;
               end
               if (|pick) begin
                  victim_d = pick;
                  state_d  = (|(pick & valid_vec & dirty_vec)) ? WB : FILL_REQ;
               end
            end
         end
         WB: begin
            bus.wb_valid = 1'b1;
            bus.wb_tag   = victim_tag;
            if (bus.wb_ready) begin
               state_d = FILL_REQ;
            end
         end
         FILL_REQ: begin
            bus.fill_valid = 1'b1;
            bus.fill_tag   = tag_q;
            if (bus.fill_ready) begin
               state_d = FILL_WAIT;
            end
         end
         FILL_WAIT: begin
            if (bus.fill_done) begin
               state_d = ALLOC;
            end
         end
         ALLOC: begin
            alloc_en         = 1'b1;
            bus.allocate_way = victim_q;
            hit_d            = 1'b0;
            way_d            = victim_q;
            state_d          = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_hit   = hit_q;
            bus.resp_way   = way_q;
            state_d        = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_set_access_controller.sv
// Directed bench for set_access_controller with a queue-based scoreboard.
// Stimulus pushes expected responses/pulses/tags; a monitor pops and compares.
// A memory responder models writeback stalls and fill completion.
module tb_set_access_controller;

   localparam int NW = 4;
   localparam int TW = 20;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   set_access_controller_if #(.NUM_WAYS(NW), .TAG_WIDTH(TW)) bus ();

   set_access_controller #(.NUM_WAYS(NW), .TAG_WIDTH(TW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          hit;
      logic [NW-1:0] way;
      int          lat;
      int          acc;
   } resp_t;

   typedef struct {
      bit            is_alloc;
      logic [NW-1:0] way;
   } pulse_t;

   resp_t         resp_q  [$];
   pulse_t        pulse_q [$];
   logic [TW-1:0] wb_q    [$];
   logic [TW-1:0] fill_q  [$];

   int n_chk     = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int wb_left   = 0;
   bit hold_done = 1'b0;
   bit fill_acc  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory side: wb_ready after wb_left stalled cycles, immediate fill_ready, fill_done next cycle.
   initial begin
      bus.wb_ready   = 1'b0;
      bus.fill_ready = 1'b0;
      bus.fill_done  = 1'b0;
      forever begin
         @(negedge clk);
         bus.fill_done = 1'b0;
         if (fill_acc) begin
            fill_acc = 1'b0;
            if (!hold_done) bus.fill_done = 1'b1;
         end
         bus.wb_ready   = 1'b0;
         bus.fill_ready = 1'b0;
         if (bus.wb_valid) begin
            if (wb_left > 0) wb_left--;
            else bus.wb_ready = 1'b1;
         end
         if (bus.fill_valid) begin
            bus.fill_ready = 1'b1;
            fill_acc       = 1'b1;
         end
      end
   end

   // Monitor: invariants every cycle, scoreboard pops on each DUT output event.
   initial begin
      pulse_t p;
      resp_t  r;
      forever begin
         @(negedge clk);
         #1;
         if (!reset) begin
            n_chk++;
            if (!$onehot0(bus.hit_way) || !$onehot0(bus.allocate_way) ||
                ((|bus.hit_way) && (|bus.allocate_way)) ||
                (bus.wb_valid && bus.fill_valid) ||
                ($countones(dut.u_store.match_o) > 1)) begin
               n_fail++;
               $display("FAIL invariant: hit_way=%b allocate_way=%b wb_valid=%b fill_valid=%b match=%b",
                        bus.hit_way, bus.allocate_way, bus.wb_valid, bus.fill_valid, dut.u_store.match_o);
            end
            if (bus.hit_way != '0) begin
               if (pulse_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected hit_way: got %b expected none", bus.hit_way);
               end else begin
                  p = pulse_q.pop_front();
                  check("hit_way pulse", 32'({bus.hit_way, 1'b0}), 32'({p.way, p.is_alloc}));
               end
            end
            if (bus.allocate_way != '0) begin
               if (pulse_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected allocate_way: got %b expected none", bus.allocate_way);
               end else begin
                  p = pulse_q.pop_front();
                  check("allocate_way pulse", 32'({bus.allocate_way, 1'b1}), 32'({p.way, p.is_alloc}));
               end
            end
            if (bus.wb_valid) begin
               if (wb_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected wb_valid: got wb_tag 0x%0h expected none", bus.wb_tag);
               end else begin
                  check("wb_tag", 32'(bus.wb_tag), 32'(wb_q[0]));
                  if (bus.wb_ready) void'(wb_q.pop_front());
               end
            end
            if (bus.fill_valid) begin
               if (fill_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected fill_valid: got fill_tag 0x%0h expected none", bus.fill_tag);
               end else begin
                  check("fill_tag", 32'(bus.fill_tag), 32'(fill_q[0]));
                  if (bus.fill_ready) void'(fill_q.pop_front());
               end
            end
            if (bus.resp_valid) begin
               if (resp_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected resp_valid: got hit=%b way=%b expected none", bus.resp_hit, bus.resp_way);
               end else begin
                  r = resp_q.pop_front();
                  check("resp_hit", 32'(bus.resp_hit), 32'(r.hit));
                  check("resp_way", 32'(bus.resp_way), 32'(r.way));
                  if (r.lat > 0) check("resp latency", 32'(cyc - r.acc), 32'(r.lat));
               end
            end
         end
      end
   end

   // Push expectations, then present one request and hold it for the accepting cycle.
   task automatic lookup(input logic [TW-1:0] tag, input bit wr, input bit hit,
                         input logic [NW-1:0] way, input int lat,
                         input bit do_wb, input logic [TW-1:0] wbt);
      int guard = 0;
      pulse_q.push_back('{!hit, way});
      if (!hit) begin
         if (do_wb) wb_q.push_back(wbt);
         fill_q.push_back(tag);
      end
      @(negedge clk);
      while (!bus.req_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      n_chk++;
      if (!bus.req_ready) begin
         n_fail++;
         $display("FAIL req_ready timeout: got 0 expected 1");
      end
      bus.req_valid = 1'b1;
      bus.req_tag   = tag;
      bus.req_write = wr;
      resp_q.push_back('{hit, way, lat, cyc});
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (resp_q.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      n_chk++;
      if (resp_q.size() != 0) begin
         n_fail++;
         $display("FAIL response timeout: got %0d pending expected 0", resp_q.size());
         resp_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid       = 1'b0;
      bus.req_tag         = '0;
      bus.req_write       = 1'b0;
      bus.eviction_target = '0;
      bus.eviction_ready  = 1'b0;
      repeat (2) @(negedge clk);

      // Reset values
      check("reset req_ready",    32'(bus.req_ready), 32'd1);
      check("reset resp_valid",   32'(bus.resp_valid), 32'd0);
      check("reset pulses",       32'({bus.hit_way, bus.allocate_way}), 32'd0);
      check("reset wb/fill",      32'({bus.wb_valid, bus.fill_valid}), 32'd0);
      check("reset tags",         32'(bus.wb_tag | bus.fill_tag), 32'd0);
      reset = 1'b0;

      // Four cold misses fill ways 0..3 in order
      lookup(20'h1, 1'b0, 1'b0, 4'b0001, 5, 1'b0, '0); wait_idle();
      lookup(20'h2, 1'b0, 1'b0, 4'b0010, 5, 1'b0, '0); wait_idle();
      lookup(20'h3, 1'b0, 1'b0, 4'b0100, 5, 1'b0, '0); wait_idle();
      lookup(20'h4, 1'b0, 1'b0, 4'b1000, 5, 1'b0, '0); wait_idle();

      // Read hit
      lookup(20'h3, 1'b0, 1'b1, 4'b0100, 2, 1'b0, '0); wait_idle();

      // Clean eviction of way 0, then the old tag misses
      bus.eviction_ready  = 1'b1;
      bus.eviction_target = 4'b0001;
      lookup(20'h9, 1'b0, 1'b0, 4'b0001, 5, 1'b0, '0); wait_idle();
      bus.eviction_target = 4'b1000;
      lookup(20'h1, 1'b0, 1'b0, 4'b1000, 5, 1'b0, '0); wait_idle();

      // Write hit dirties way 1; evicting it forces a stalled writeback
      lookup(20'h2, 1'b1, 1'b1, 4'b0010, 2, 1'b0, '0); wait_idle();
      bus.eviction_target = 4'b0010;
      wb_left = 3;
      lookup(20'hA, 1'b0, 1'b0, 4'b0010, 9, 1'b1, 20'h2); wait_idle();

      // Full set with no LRU target: stall four cycles in LOOKUP
      bus.eviction_ready  = 1'b0;
      bus.eviction_target = 4'b0100;
      lookup(20'hB, 1'b0, 1'b0, 4'b0100, 9, 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         check("stall req_ready", 32'(bus.req_ready), 32'd0);
         check("stall pulses",    32'({bus.hit_way, bus.allocate_way}), 32'd0);
         check("stall fill_valid", 32'(bus.fill_valid), 32'd0);
      end
      @(negedge clk);
      bus.eviction_ready = 1'b1;
      wait_idle();

      // Reset while waiting for fill data abandons the request
      bus.eviction_target = 4'b0001;
      hold_done = 1'b1;
      lookup(20'hC, 1'b0, 1'b0, 4'b0001, 0, 1'b0, '0);
      @(negedge clk);
      @(negedge clk);
      check("fill accepted before reset", 32'(fill_q.size()), 32'd0);
      reset = 1'b1;
      resp_q.delete();
      pulse_q.delete();
      @(negedge clk);
      check("post-reset req_ready",  32'(bus.req_ready), 32'd1);
      check("post-reset resp_valid", 32'(bus.resp_valid), 32'd0);
      reset     = 1'b0;
      hold_done = 1'b0;
      repeat (3) @(negedge clk);

      // Previously resident tag now misses into the lowest free way
      lookup(20'hB, 1'b0, 1'b0, 4'b0001, 5, 1'b0, '0); wait_idle();

      check("resp queue drained",  32'(resp_q.size()), 32'd0);
      check("pulse queue drained", 32'(pulse_q.size()), 32'd0);
      check("wb queue drained",    32'(wb_q.size()), 32'd0);
      check("fill queue drained",  32'(fill_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/set_access_controller.md
Name: set_access_controller

Overview:
- Per-set access controller directly upstream of the LRU eviction policy block.
- Accepts tag lookups for one cache set of NUM_WAYS ways and holds each way's tag, valid and dirty state.
- Resolves hit or miss. On a miss it chooses a victim: the lowest-index invalid way, otherwise the LRU eviction target.
- Sequences writeback and fill handshakes with the memory side. Drives one-cycle one-hot hit_way / allocate_way pulses that feed the LRU block's hitWay / allocateWay inputs.

Parameters:
- NUM_WAYS, 4, ways per set; power of two, at least 2.
- TAG_WIDTH, 20, tag bits per way.

Ports:
- clk  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset; clears all state.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  controller can accept a request.
- req_tag  in  TAG_WIDTH  tag to look up.
- req_write  in  1  request is a store; the accessed line becomes dirty.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  1 = hit, 0 = miss serviced; valid with resp_valid.
- resp_way  out  NUM_WAYS  one-hot way used; valid with resp_valid.
- hit_way  out  NUM_WAYS  one-hot hit pulse to the LRU block.
- allocate_way  out  NUM_WAYS  one-hot allocate pulse to the LRU block.
- eviction_target  in  NUM_WAYS  one-hot LRU victim from the LRU block.
- eviction_ready  in  1  eviction_target is valid.
- wb_valid  out  1  writeback request.
- wb_ready  in  1  writeback accepted.
- wb_tag  out  TAG_WIDTH  tag of the dirty victim.
- fill_valid  out  1  fill request.
- fill_ready  in  1  fill request accepted.
- fill_tag  out  TAG_WIDTH  tag to fetch; equals the captured req_tag.
- fill_done  in  1  fill data has arrived.

Behaviour:
- Reset state and outputs:
  - state = IDLE; all valid and dirty bits 0; tags 0.
  - req_ready = 1; all other outputs 0.
  - The LRU block must be reset in the same cycle, so its ages re-initialise together with this block.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: capture req_tag and req_write, then go to LOOKUP.
- LOOKUP:
  - Compare the captured tag against every valid way in the same cycle.
  - Hit:
    - hit_way = matching one-hot for exactly this cycle.
    - If the captured write flag is set, set that way's dirty bit.
    - Record hit = 1 and the way, then go to RESP.
  - Miss, victim selection:
    - If any way is invalid, the victim is the lowest-index invalid way.
    - Else if eviction_ready, the victim is eviction_target.
    - Else stay in LOOKUP (stall) with no pulses.
  - Miss, next state: if the victim is valid and dirty, go to WB; otherwise go to FILL_REQ.
  - eviction_target is sampled before any LRU update; it is never sampled in a cycle in which hit_way or allocate_way is nonzero.
- WB:
  - wb_valid = 1 and wb_tag = victim tag, both held stable until wb_ready.
  - On wb_ready, go to FILL_REQ.
- FILL_REQ:
  - fill_valid = 1 and fill_tag = captured tag, held stable until fill_ready.
  - On fill_ready, go to FILL_WAIT.
  - fill_valid and wb_valid are never high together.
- FILL_WAIT: wait for fill_done, then go to ALLOC. fill_done is ignored in every other state.
- ALLOC:
  - Write the victim's tag; set valid = 1; set dirty = captured write flag.
  - allocate_way = victim one-hot for exactly this cycle.
  - Record hit = 0, then go to RESP.
- RESP: resp_valid = 1 for one cycle with resp_hit and resp_way, then go to IDLE.
- req_ready is 1 only in IDLE; there is one outstanding request at a time.
- Latency:
  - Hit: accepted at cycle 0, hit_way pulse at cycle 1, resp_valid at cycle 2.
  - Clean miss with an immediate handshake and fill_done one cycle after fill_ready: resp_valid at cycle 5.
- Invariants:
  - hit_way and allocate_way are each zero or one-hot, and never both nonzero in the same cycle.
  - At most one valid way matches a given tag; a bench assertion checks this.
- Protocol error: if eviction_target is not one-hot while eviction_ready = 1, use its lowest set bit.
- Reset mid-operation:
  - An asynchronous reset from any state returns to IDLE immediately and clears valid/dirty.
  - An outstanding writeback or fill is abandoned; no resp_valid is generated.

Decomposition:
- cache_pkg holds:
  - the state enum (IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT, ALLOC, RESP);
  - the lowest-set-bit one-hot function, shared with the LRU block;
  - the one-hot-to-index function.
- Sub-module set_tag_store holds:
  - per-way tag/valid/dirty registers;
  - the combinational match vector and the lowest-invalid-way one-hot;
  - a write port for allocate and a write port for set-dirty.
- The FSM and the handshakes remain in set_access_controller.

Test Plan:
- Reset, then four misses with tags 0x1, 0x2, 0x3, 0x4 and immediate ready/done -> allocate_way = 0001, 0010, 0100, 1000 in order; resp_hit = 0 each time; no wb_valid.
- Lookup of tag 0x3 after fill -> hit_way = 0100 at cycle 1; resp_valid with resp_hit = 1 and resp_way = 0100 at cycle 2; allocate_way stays 0.
- Set full and clean, eviction_ready = 1 with eviction_target = 0001, miss on tag 0x9 -> no wb_valid; fill_tag = 0x9; allocate_way = 0001; a later lookup of 0x1 misses.
- Write hit on tag 0x2 sets way 1 dirty; then a miss with eviction_target = 0010 -> wb_valid with wb_tag = 0x2, held for 3 cycles of wb_ready = 0; then fill_valid; allocate_way = 0010.
- Set full, miss with eviction_ready = 0 for 4 cycles -> stays in LOOKUP, no pulses, req_ready = 0; proceeds on the cycle eviction_ready rises.
- Reset asserted in FILL_WAIT -> next edge shows req_ready = 1, no resp_valid; a lookup of the previously filled tag misses.
